// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: sole owner of the register file write port and read-address muxes.
// Core writeback and multi-cycle SWAP requests share the single write port. A SWAP runs
// as read / write A / write B, so the register file itself needs no swap logic.
//
// Handshakes: wb_req is granted combinationally (wb_gnt) in the cycle it is offered,
// only while IDLE. swap_req is level-held by the requester until the one-cycle swap_gnt
// pulse. Operand addresses are captured in that grant cycle only. A writeback that loses
// arbitration simply stays pending; nothing is queued here.
module rf_write_scheduler #(
  parameter int PW     = 4,
  parameter int DW     = 8,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_req,
  input  logic [PW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_gnt,
  input  logic          swap_req,
  input  logic [PW-1:0] swap_addr_a,
  input  logic [PW-1:0] swap_addr_b,
  output logic          swap_gnt,
  output logic          swap_done,
  input  logic [PW-1:0] core_rd_a,
  input  logic [PW-1:0] core_rd_b,
  output logic [PW-1:0] rf_rd_addr_a,
  output logic [PW-1:0] rf_rd_addr_b,
  input  logic [DW-1:0] rf_dat_a,
  input  logic [DW-1:0] rf_dat_b,
  output logic          rf_wr_en,
  output logic [PW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          stall
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SWAP_RD  = 2'd1,
    S_SWAP_WR1 = 2'd2,
    S_SWAP_WR2 = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] starve_cnt;
  logic [PW-1:0] cap_a;
  logic [PW-1:0] cap_b;
  logic [DW-1:0] tmp_a;
  logic [DW-1:0] tmp_b;
  logic          starved;
  logic          swap_win;

  // Swap takes the port when writeback is absent or has already beaten it STARVE times.
  // Qualified with rst_n so no grant can be seen while reset is held.
  assign starved  = (starve_cnt == SW'(STARVE));
  assign swap_win = rst_n && (state_q == S_IDLE) && swap_req && (!wb_req || starved);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, arbitration, write-port and read-mux drive.
  always_comb begin
    state_d      = state_q;
    wb_gnt       = 1'b0;
    swap_gnt     = 1'b0;
    swap_done    = 1'b0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    rf_wr_data   = '0;
    rf_rd_addr_a = core_rd_a;
    rf_rd_addr_b = core_rd_b;
    stall        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (swap_win) begin
          swap_gnt = 1'b1;
          state_d  = S_SWAP_RD;
        end else if (rst_n && wb_req) begin
          wb_gnt     = 1'b1;
          rf_wr_en   = 1'b1;
          rf_wr_addr = wb_addr;
          rf_wr_data = wb_data;
        end
      end
      S_SWAP_RD: begin
        stall        = 1'b1;
        rf_rd_addr_a = cap_a;
        rf_rd_addr_b = cap_b;
        state_d      = S_SWAP_WR1;
      end
      S_SWAP_WR1: begin
        stall        = 1'b1;
        rf_rd_addr_a = cap_a;
        rf_rd_addr_b = cap_b;
        rf_wr_en     = 1'b1;
        rf_wr_addr   = cap_a;
        rf_wr_data   = tmp_b;
        state_d      = S_SWAP_WR2;
      end
      S_SWAP_WR2: begin
        stall        = 1'b1;
        rf_rd_addr_a = cap_a;
        rf_rd_addr_b = cap_b;
        rf_wr_en     = 1'b1;
        rf_wr_addr   = cap_b;
        rf_wr_data   = tmp_a;
        swap_done    = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture at grant, and the pre-swap values read in SWAP_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a <= '0;
      cap_b <= '0;
      tmp_a <= '0;
      tmp_b <= '0;
    end else begin
      if (swap_gnt) begin
        cap_a <= swap_addr_a;
        cap_b <= swap_addr_b;
      end
      if (state_q == S_SWAP_RD) begin
        tmp_a <= rf_dat_a;
        tmp_b <= rf_dat_b;
      end
    end
  end

  // Count consecutive writeback wins over a waiting swap, saturating at STARVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (swap_gnt || !swap_req) begin
      starve_cnt <= '0;
    end else if (wb_gnt && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a behavioural register file attached.
module tb_rf_write_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_req;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_gnt;
  logic       swap_req;
  logic [3:0] swap_addr_a;
  logic [3:0] swap_addr_b;
  logic       swap_gnt;
  logic       swap_done;
  logic [3:0] core_rd_a;
  logic [3:0] core_rd_b;
  logic [3:0] rf_rd_addr_a;
  logic [3:0] rf_rd_addr_b;
  logic [7:0] rf_dat_a;
  logic [7:0] rf_dat_b;
  logic       rf_wr_en;
  logic [3:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       stall;

  logic [7:0] rf [16];
  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  rf_write_scheduler #(.PW(4), .DW(8), .STARVE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .swap_req(swap_req), .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b),
    .swap_gnt(swap_gnt), .swap_done(swap_done),
    .core_rd_a(core_rd_a), .core_rd_b(core_rd_b),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_dat_a(rf_dat_a), .rf_dat_b(rf_dat_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .stall(stall)
  );

  // Behavioural register file: combinational read, write on rising edge.
  assign rf_dat_a = rf[rf_rd_addr_a];
  assign rf_dat_b = rf[rf_rd_addr_b];
  always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change there, outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [7:0] d);
    chk({tag, "_en"}, rf_wr_en, en);
    if (en) begin
      chk({tag, "_addr"}, rf_wr_addr, a);
      chk({tag, "_data"}, rf_wr_data, d);
    end
  endtask

  initial begin
    rst_n = 1'b0; wb_req = 1'b1; wb_addr = 4'd9; wb_data = 8'hEE;
    swap_req = 1'b1; swap_addr_a = 4'd1; swap_addr_b = 4'd2;
    core_rd_a = 4'd1; core_rd_b = 4'd2;
    for (int i = 0; i < 16; i++) rf[i] = 8'(i);
    rf[2] = 8'h11; rf[5] = 8'h22; rf[7] = 8'h3C;

    // Reset: requests present but nothing granted, read mux passes core addresses.
    #1;
    chk("rst_wb_gnt", wb_gnt, 0);
    chk("rst_swap_gnt", swap_gnt, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rd_a", rf_rd_addr_a, 4'd1);
    chk("rst_rd_b", rf_rd_addr_b, 4'd2);
    step(); step();
    rst_n = 1'b1; swap_req = 1'b0; wb_req = 1'b0;

    // 1: writeback only, zero latency.
    step(); wb_req = 1'b1; wb_addr = 4'd3; wb_data = 8'hA5; #1;
    chk("t1_wb_gnt", wb_gnt, 1);
    chk_wr("t1_wr", 1, 4'd3, 8'hA5);
    chk("t1_stall", stall, 0);
    chk("t1_swap_gnt", swap_gnt, 0);

    // 2 + 6: swap r2<->r5, request dropped and addresses scrambled after the grant.
    step(); wb_req = 1'b0; swap_req = 1'b1; swap_addr_a = 4'd2; swap_addr_b = 4'd5;
    core_rd_a = 4'd4; core_rd_b = 4'd6; #1;
    chk("t2_T_gnt", swap_gnt, 1);
    chk("t2_T_stall", stall, 0);
    chk("t2_T_wr", rf_wr_en, 0);
    chk("t2_T_rd_a", rf_rd_addr_a, 4'd4);
    step(); swap_req = 1'b0; swap_addr_a = 4'd9; swap_addr_b = 4'd9; #1;
    chk("t2_T1_stall", stall, 1);
    chk("t2_T1_gnt", swap_gnt, 0);
    chk("t2_T1_rd_a", rf_rd_addr_a, 4'd2);
    chk("t2_T1_rd_b", rf_rd_addr_b, 4'd5);
    chk("t2_T1_wr", rf_wr_en, 0);
    step(); #1;
    chk_wr("t2_T2", 1, 4'd2, 8'h22);
    chk("t2_T2_done", swap_done, 0);
    chk("t2_T2_stall", stall, 1);
    step(); #1;
    chk_wr("t2_T3", 1, 4'd5, 8'h11);
    chk("t2_T3_done", swap_done, 1);
    chk("t2_T3_stall", stall, 1);
    step(); #1;
    chk("t2_T4_stall", stall, 0);
    chk("t2_T4_done", swap_done, 0);
    chk("t2_T4_rd_a", rf_rd_addr_a, 4'd4);
    chk("t2_T4_rd_b", rf_rd_addr_b, 4'd6);
    chk("t2_r2", rf[2], 8'h22);
    chk("t2_r5", rf[5], 8'h11);

    // 3: contention; wb wins 3 cycles, swap (r1<->r3, r3=A5) wins the 4th.
    step(); wb_req = 1'b1; wb_addr = 4'd8; wb_data = 8'h5A;
    swap_req = 1'b1; swap_addr_a = 4'd1; swap_addr_b = 4'd3; #1;
    chk("t3_c0_wb", wb_gnt, 1);
    chk("t3_c0_swap", swap_gnt, 0);
    step(); #1;
    chk("t3_c1_wb", wb_gnt, 1);
    chk("t3_c1_swap", swap_gnt, 0);
    step(); #1;
    chk("t3_c2_wb", wb_gnt, 1);
    chk("t3_c2_swap", swap_gnt, 0);
    step(); #1;
    chk("t3_c3_wb", wb_gnt, 0);
    chk("t3_c3_swap", swap_gnt, 1);
    chk("t3_c3_wr", rf_wr_en, 0);
    step(); swap_req = 1'b0; #1;
    chk("t3_c4_wb", wb_gnt, 0);
    chk("t3_c4_stall", stall, 1);
    step(); #1;
    chk("t3_c5_wb", wb_gnt, 0);
    chk_wr("t3_c5", 1, 4'd1, 8'hA5);
    step(); #1;
    chk("t3_c6_wb", wb_gnt, 0);
    chk_wr("t3_c6", 1, 4'd3, 8'h01);
    step(); #1;
    chk("t3_c7_wb", wb_gnt, 1);
    chk_wr("t3_c7", 1, 4'd8, 8'h5A);
    chk("t3_c7_stall", stall, 0);

    // 4: self-swap of r7.
    step(); wb_req = 1'b0; swap_req = 1'b1; swap_addr_a = 4'd7; swap_addr_b = 4'd7; #1;
    chk("t4_T_gnt", swap_gnt, 1);
    step(); swap_req = 1'b0; #1;
    chk("t4_T1_wr", rf_wr_en, 0);
    step(); #1;
    chk_wr("t4_T2", 1, 4'd7, 8'h3C);
    step(); #1;
    chk_wr("t4_T3", 1, 4'd7, 8'h3C);
    chk("t4_T3_done", swap_done, 1);
    step(); #1;
    chk("t4_r7", rf[7], 8'h3C);
    chk("t4_r1", rf[1], 8'hA5);
    chk("t4_r3", rf[3], 8'h01);

    // 5: reset during SWAP_WR1 of r2<->r5 (r2=22, r5=11); WR1 and WR2 both abandoned.
    step(); swap_req = 1'b1; swap_addr_a = 4'd2; swap_addr_b = 4'd5; #1;
    chk("t5_T_gnt", swap_gnt, 1);
    step(); swap_req = 1'b0; #1;
    step(); #1;
    chk_wr("t5_T2_pre", 1, 4'd2, 8'h11);
    #1; rst_n = 1'b0; #1;
    chk("t5_rst_wr", rf_wr_en, 0);
    chk("t5_rst_wr_addr", rf_wr_addr, 0);
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_done", swap_done, 0);
    chk("t5_rst_rd_a", rf_rd_addr_a, 4'd4);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("t5_post_wr", rf_wr_en, 0);
      chk("t5_post_stall", stall, 0);
      chk("t5_post_done", swap_done, 0);
    end
    chk("t5_r2", rf[2], 8'h22);
    chk("t5_r5", rf[5], 8'h11);

    // Starvation counter restarts after reset: fresh contention again needs 3 wb wins.
    step(); wb_req = 1'b1; wb_addr = 4'd10; wb_data = 8'h77; swap_req = 1'b1;
    swap_addr_a = 4'd10; swap_addr_b = 4'd11; #1;
    chk("t7_c0_wb", wb_gnt, 1);
    step(); #1;
    chk("t7_c1_wb", wb_gnt, 1);
    step(); #1;
    chk("t7_c2_wb", wb_gnt, 1);
    step(); #1;
    chk("t7_c3_swap", swap_gnt, 1);
    step(); wb_req = 1'b0; swap_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
